// File: rtl/pline_rr_sched.sv
// -----------------------------------------------------------------------------
// pline_rr_sched
// Round-robin scheduler sharing one fixed-latency external pipeline ("pline")
// between P_NREQ requesters. At most one requester is granted per cycle; its
// word is registered onto pl_a. A {valid, tag} shift register travels alongside
// the external pipeline so each result on pl_y is strobed back to its issuer.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   req        in   per-requester request level
//   req_data   in   requester i word in bits [i*P_WIDTH +: P_WIDTH]
//   hold       in   1 = issue no new grants this cycle
//   gnt        out  one-hot grant, combinational in the request cycle
//   pl_a       out  registered word to the pipeline input
//   pl_y       in   output of the external pipeline
//   rsp_valid  out  one-hot result strobe
//   rsp_data   out  result word (pl_y passed through)
//   inflight   out  issued words not yet returned
//   idle       out  inflight==0 and no grant this cycle
// -----------------------------------------------------------------------------
module pline_rr_sched #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 4,
    parameter int P_NREQ  = 4,
    parameter int P_TAGW  = 2,
    localparam int P_CNTW = $clog2(P_DEPTH + 2)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [P_NREQ-1:0]           req,
    input  logic [P_NREQ*P_WIDTH-1:0]   req_data,
    input  logic                        hold,
    output logic [P_NREQ-1:0]           gnt,
    output logic [P_WIDTH-1:0]          pl_a,
    input  logic [P_WIDTH-1:0]          pl_y,
    output logic [P_NREQ-1:0]           rsp_valid,
    output logic [P_WIDTH-1:0]          rsp_data,
    output logic [P_CNTW-1:0]           inflight,
    output logic                        idle
);

    logic [P_TAGW-1:0]              ptr_q, ptr_d;
    logic [P_WIDTH-1:0]             pl_a_q, pl_a_d;
    logic [P_DEPTH:0]               vld_q, vld_d;
    logic [P_DEPTH:0][P_TAGW-1:0]   tag_q, tag_d;
    logic [P_CNTW-1:0]              inflight_q, inflight_d;

    logic [P_NREQ-1:0]              gnt_s;
    logic [P_TAGW-1:0]              gnt_idx_s;
    logic                           issue_s;
    logic                           retire_s;
    logic [P_NREQ-1:0]              rsp_valid_s;

    // Round-robin search starting just above the last granted index.
    always_comb begin
        int                 idx_v;
        logic [P_TAGW-1:0]  cand_v;
        logic               found_v;
        gnt_s     = '0;
        gnt_idx_s = '0;
        found_v   = 1'b0;
        idx_v     = 0;
        cand_v    = '0;
        for (int i = 1; i <= P_NREQ; i++) begin
            idx_v     = (int'(ptr_q) + i) % P_NREQ;
            cand_v    = P_TAGW'(idx_v);
            // First hit wins; later hits leave the selection untouched.
            gnt_idx_s = (!found_v && req[cand_v]) ? cand_v : gnt_idx_s;
            found_v   = found_v | req[cand_v];
        end
        if (!hold && found_v) begin
            gnt_s[gnt_idx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    assign issue_s  = |gnt_s;
    assign retire_s = vld_q[P_DEPTH];

    // Next-state for issue register, pointer, shift register and inflight count.
    always_comb begin
        ptr_d      = ptr_q;
        pl_a_d     = pl_a_q;
        vld_d      = {vld_q[P_DEPTH-1:0], issue_s};
        tag_d      = {tag_q[P_DEPTH-1:0], gnt_idx_s};
        inflight_d = inflight_q;
        if (issue_s) begin
            ptr_d  = gnt_idx_s;
            pl_a_d = req_data[int'(gnt_idx_s)*P_WIDTH +: P_WIDTH];
        end else begin
            ptr_d  = ptr_q;
            pl_a_d = pl_a_q;
        end
        // An issue and a retirement on the same edge cancel out.
        case ({issue_s, retire_s})
            2'b10:   inflight_d = inflight_q + P_CNTW'(1);
            2'b01:   inflight_d = inflight_q - P_CNTW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers; reset discards every in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= P_TAGW'(P_NREQ - 1);
            pl_a_q     <= '0;
            vld_q      <= '0;
            tag_q      <= '0;
            inflight_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            pl_a_q     <= pl_a_d;
            vld_q      <= vld_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    // Decode the last stage into the response strobe; invalid stages stay silent.
    always_comb begin
        rsp_valid_s = '0;
        if (vld_q[P_DEPTH]) begin
            rsp_valid_s[tag_q[P_DEPTH]] = 1'b1;
        end else begin
            rsp_valid_s = '0;
        end
    end

    assign gnt       = gnt_s;
    assign pl_a      = pl_a_q;
    assign rsp_valid = rsp_valid_s;
    assign rsp_data  = pl_y;
    assign inflight  = inflight_q;
    assign idle      = (inflight_q == '0) && !issue_s;

endmodule
